// File: rtl/fetch_seq.sv
// Multicycle fetch sequencer: owns the PC, fetches one instruction per
// req/ack handshake, holds it until retirement and then computes the next PC.
module fetch_seq #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int          IMEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        retire,
  input  logic [3:0]  branch,
  input  logic [31:0] imm32,
  input  logic        alu_change,
  output logic [31:0] retired_cnt,
  output logic        error
);

  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERROR} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] instr_pc_reg, instr_pc_next;
  logic [31:0] cnt_reg, cnt_next;

  logic [31:0] pc4;
  logic [31:0] npc;
  logic [31:0] npc_off;
  logic        npc_legal;

  // Next-PC selection; all arithmetic is modulo 2^32.
  always_comb begin
    pc4 = pc_reg + 32'd4;
    case (branch)
      4'b0001: npc = pc4;
      4'b0010: npc = alu_change ? pc4 + {imm32[29:0], 2'b00} : pc4;
      4'b0100: npc = {pc_reg[31:28], imm32[25:0], 2'b00};
      default: npc = imm32;
    endcase
    npc_off   = npc - IMEM_BASE;
    npc_legal = (npc[1:0] == 2'b00) && (npc >= IMEM_BASE) && (npc_off < IMEM_BYTES);
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;
    cnt_next      = cnt_reg;
    case (state_reg)
      IDLE: state_next = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_next    = imem_rdata;
          instr_pc_next = pc_reg;
          state_next    = HOLD;
        end
      end
      HOLD: begin
        if (retire) begin
          pc_next    = npc;
          cnt_next   = cnt_reg + 32'd1;
          state_next = npc_legal ? FETCH : ERROR;
        end
      end
      default: state_next = ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      instr_reg    <= '0;
      instr_pc_reg <= RESET_PC;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      instr_pc_reg <= instr_pc_next;
      cnt_reg      <= cnt_next;
    end
  end

  // Handshake and status outputs are pure state decodes.
  assign imem_req    = (state_reg == FETCH);
  assign imem_addr   = pc_reg;
  assign instr_valid = (state_reg == HOLD);
  assign error       = (state_reg == ERROR);
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;
  assign retired_cnt = cnt_reg;

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: directed fetch/retire vectors push expected
// fetch addresses and held instructions; a monitor pops and compares.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        retire;
  logic [3:0]  branch;
  logic [31:0] imm32;
  logic        alu_change;
  logic [31:0] retired_cnt;
  logic        error;

  fetch_seq dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .retire(retire), .branch(branch), .imm32(imm32), .alu_change(alu_change),
    .retired_cnt(retired_cnt), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_hold_q[$];
  logic [31:0] exp_cnt = 0;
  logic        prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: handshakes and HOLD entries are compared against the queues.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid <= 1'b0;
    end else begin
      if (imem_req && imem_ack) begin
        if (exp_addr_q.size() == 0) begin
          check("fetch_unexpected", imem_addr, 32'hxxxx_xxxx);
        end else begin
          logic [31:0] ea;
          ea = exp_addr_q.pop_front();
          check("fetch_addr", imem_addr, ea);
          $display("txn fetch addr=%h rdata=%h", imem_addr, imem_rdata);
        end
      end
      if (instr_valid && !prev_valid) begin
        if (exp_hold_q.size() == 0) begin
          check("hold_unexpected", instr_pc, 32'hxxxx_xxxx);
        end else begin
          logic [63:0] eh;
          eh = exp_hold_q.pop_front();
          check("hold_instr", instr, eh[63:32]);
          check("hold_pc", instr_pc, eh[31:0]);
          $display("txn hold instr=%h pc=%h", instr, instr_pc);
        end
      end
      prev_valid <= instr_valid;
    end
  end

  // Waits for a request, inserts wait states, then acks with word.
  task automatic fetch(input int waits, input logic [31:0] word, input logic [31:0] pc);
    int n;
    exp_addr_q.push_back(pc);
    exp_hold_q.push_back({word, pc});
    n = 0;
    while (!imem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_timeout", {31'd0, imem_req}, 32'd1);
    for (int w = 0; w < waits; w++) begin
      retire = (w == 0);
      branch = 4'b1000;
      imm32  = 32'h0000_3100;
      @(posedge clk); #1;
      retire = 1'b0;
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_addr", imem_addr, pc);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
      check("wait_cnt", retired_cnt, exp_cnt);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    check("valid_after_ack", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic retire_op(input logic [3:0] br, input logic [31:0] imm, input logic alu,
                           input logic [31:0] exp_pc, input logic exp_err);
    retire     = 1'b1;
    branch     = br;
    imm32      = imm;
    alu_change = alu;
    @(posedge clk); #1;
    retire     = 1'b0;
    alu_change = 1'b0;
    exp_cnt    = exp_cnt + 32'd1;
    check("retired_cnt", retired_cnt, exp_cnt);
    check("error", {31'd0, error}, {31'd0, exp_err});
    check("req_after_retire", {31'd0, imem_req}, {31'd0, !exp_err});
    check("npc", imem_addr, exp_pc);
    $display("txn retire branch=%b imm=%h next=%h err=%0d", br, imm, imem_addr, error);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    #1;
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_pc", imem_addr, 32'h0000_3000);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_cnt", retired_cnt, 32'd0);
    exp_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; retire = 1'b0;
    branch = 4'b0001; imm32 = 32'h0; alu_change = 1'b0;
    #3;
    check("rst_instr", instr, 32'h0);
    do_reset();
    check("idle_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    check("first_fetch_req", {31'd0, imem_req}, 32'd1);

    // Sequential, zero-wait
    for (int i = 0; i < 3; i++) begin
      fetch(0, 32'h1111_0000 + i, 32'h3000 + 32'(4 * i));
      retire_op(4'b0001, 32'h0, 1'b0, 32'h3004 + 32'(4 * i), 1'b0);
    end
    check("seq_cnt3", retired_cnt, 32'd3);

    // Conditional branch taken backwards, then not taken
    fetch(0, 32'hA000_0001, 32'h300C);
    retire_op(4'b0001, 32'h0, 1'b0, 32'h3010, 1'b0);
    fetch(0, 32'hA000_0002, 32'h3010);
    retire_op(4'b0010, 32'hFFFF_FFFE, 1'b1, 32'h300C, 1'b0);
    fetch(0, 32'hA000_0003, 32'h300C);
    retire_op(4'b0001, 32'h0, 1'b0, 32'h3010, 1'b0);
    fetch(0, 32'hA000_0004, 32'h3010);
    retire_op(4'b0010, 32'hFFFF_FFFE, 1'b0, 32'h3014, 1'b0);

    // Jumps: register jump home, 26-bit jump, register jumps incl. branch=0000
    fetch(0, 32'hB000_0001, 32'h3014);
    retire_op(4'b1000, 32'h0000_3000, 1'b0, 32'h3000, 1'b0);
    fetch(0, 32'hB000_0002, 32'h3000);
    retire_op(4'b0100, 32'h0000_0C10, 1'b0, 32'h3040, 1'b0);
    fetch(0, 32'hB000_0003, 32'h3040);
    retire_op(4'b1000, 32'h0000_3100, 1'b0, 32'h3100, 1'b0);
    fetch(0, 32'hB000_0004, 32'h3100);
    retire_op(4'b0000, 32'h0000_3200, 1'b0, 32'h3200, 1'b0);

    // Wait states with a spurious retire, then last legal word
    fetch(3, 32'hC000_0001, 32'h3200);
    retire_op(4'b1000, 32'h0000_6FFC, 1'b0, 32'h6FFC, 1'b0);
    fetch(2, 32'hC000_0002, 32'h6FFC);

    // Fault A: misaligned; ack/retire ignored in ERROR
    retire_op(4'b1000, 32'h0000_3002, 1'b0, 32'h3002, 1'b1);
    imem_ack = 1'b1; retire = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0; retire = 1'b0;
    check("err_sticky", {31'd0, error}, 32'd1);
    check("err_cnt_hold", retired_cnt, exp_cnt);
    check("err_valid", {31'd0, instr_valid}, 32'd0);
    do_reset();

    // Fault B: one word past the range
    fetch(0, 32'hD000_0001, 32'h3000);
    retire_op(4'b1000, 32'h0000_7000, 1'b0, 32'h7000, 1'b1);
    do_reset();

    // Async reset while holding
    fetch(0, 32'hE000_0001, 32'h3000);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("async_valid_drop", {31'd0, instr_valid}, 32'd0);
    check("async_cnt", retired_cnt, 32'd0);
    exp_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Counter wrap
    fetch(0, 32'hF000_0001, 32'h3000);
    dut.cnt_reg = 32'hFFFF_FFFF;
    exp_cnt = 32'hFFFF_FFFF;
    #1;
    check("cnt_preset", retired_cnt, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    retire_op(4'b0001, 32'h0, 1'b0, 32'h3004, 1'b0);
    check("cnt_wrap", retired_cnt, 32'h0);
    fetch(1, 32'hF000_0002, 32'h3004);

    @(negedge clk); #1;
    check("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    check("hold_q_drained", 32'(exp_hold_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
